// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage RV32I pipeline.
//
// This stage sits between execute and wb_stage. It takes the ALU result and
// the store data from EX. It runs byte, half and word loads and stores against
// a data memory that uses a ready handshake. It also holds the MEM/WB pipeline
// register. While a memory transaction is outstanding, it stalls upstream.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   When defined, misaligned half/word accesses issue no bus request. They
//   complete in one cycle with wb_reg_write=0 and pulse the extra `misaligned`
//   output. When undefined, misaligned accesses use the aligned word.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, flush     EX/MEM holds a real instruction / squash it
//   pc                  link value, passed through to wb_pc
//   alu_result          effective address, or the result of a non-memory op
//   rs2_data            store data
//   mem_read, mem_write load / store (both high is treated as a store)
//   funct3              access size and signedness
//   mem_to_reg, jump, reg_write, rd   writeback controls
//   stall               upstream must hold its EX/MEM inputs
//   dmem_*              data memory request / response port
//   wb_*                MEM/WB register outputs feeding wb_stage
//   misaligned          (only with MEM_MISALIGN_TRAP_EN) misaligned access flag
module mem_stage #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_WORDS = 1024,
  parameter int ADDR_SIZE = $clog2(NUM_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 flush,
  input  logic [ADDR_SIZE-1:0] pc,
  input  logic [WORD_SIZE-1:0] alu_result,
  input  logic [WORD_SIZE-1:0] rs2_data,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [2:0]           funct3,
  input  logic                 mem_to_reg,
  input  logic                 jump,
  input  logic                 reg_write,
  input  logic [4:0]           rd,
  output logic                 stall,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [WORD_SIZE-1:0] dmem_addr,
  output logic [3:0]           dmem_be,
  output logic [WORD_SIZE-1:0] dmem_wdata,
  input  logic [WORD_SIZE-1:0] dmem_rdata,
  input  logic                 dmem_ready,
  output logic                 wb_valid,
  output logic                 wb_mem_to_reg,
  output logic                 wb_jump,
  output logic                 wb_reg_write,
  output logic [4:0]           wb_rd,
  output logic [ADDR_SIZE-1:0] wb_pc,
  output logic [WORD_SIZE-1:0] wb_memory_data,
  output logic [WORD_SIZE-1:0] wb_alu_data
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                 misaligned
`endif
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state_q, state_d;

  // The request is captured here when the access is accepted. It then stays
  // stable on the bus until dmem_ready, even if upstream inputs move.
  logic [WORD_SIZE-1:0] alu_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [3:0]           be_q;
  logic                 we_q;
  logic                 load_q;
  logic [2:0]           funct3_q;
  logic                 memToReg_q;
  logic                 jump_q;
  logic                 regWrite_q;
  logic [4:0]           rd_q;
  logic [ADDR_SIZE-1:0] pc_q;
  logic                 flushed_q, flushed_d;

  logic                 wbValid_q, wbValid_d;
  logic                 wbMemToReg_q, wbMemToReg_d;
  logic                 wbJump_q, wbJump_d;
  logic                 wbRegWrite_q, wbRegWrite_d;
  logic [4:0]           wbRd_q, wbRd_d;
  logic [ADDR_SIZE-1:0] wbPc_q, wbPc_d;
  logic [WORD_SIZE-1:0] wbMem_q, wbMem_d;
  logic [WORD_SIZE-1:0] wbAlu_q, wbAlu_d;
  logic                 misal_q, misal_d;

  logic                 isMemOp;
  logic                 startAccess;
  logic                 misalignNew;
  logic [1:0]           offNew;
  logic [3:0]           beNew;
  logic [WORD_SIZE-1:0] wdataNew;
  logic [WORD_SIZE-1:0] byteLane;
  logic [WORD_SIZE-1:0] halfLane;
  logic [WORD_SIZE-1:0] loadData;
  logic                 stallRaw;

  assign isMemOp = mem_read | mem_write;
  assign offNew  = alu_result[1:0];

  // Store lanes and replicated data. funct3[1:0] selects the size. Loads
  // reuse the same lane pattern, and memory may ignore it for reads.
  always_comb begin
    beNew    = 4'b1111;
    wdataNew = rs2_data;
    case (funct3[1:0])
      2'b00: begin
        beNew    = 4'b0001 << offNew;
        wdataNew = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        beNew    = 4'b0011 << {offNew[1], 1'b0};
        wdataNew = {2{rs2_data[15:0]}};
      end
      default: begin
        beNew    = 4'b1111;
        wdataNew = rs2_data;
      end
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misalignNew = 1'b0;
    if (in_valid && isMemOp) begin
      case (funct3[1:0])
        2'b00:   misalignNew = 1'b0;
        2'b01:   misalignNew = offNew[0];
        default: misalignNew = (offNew != 2'b00);
      endcase
    end
  end
`else
  assign misalignNew = 1'b0;
`endif

  // Load extraction uses the latched byte offset. The lane is shifted down to
  // bit 0 and then extended according to the latched funct3.
  assign byteLane = dmem_rdata >> {alu_q[1:0], 3'b000};
  assign halfLane = dmem_rdata >> {alu_q[1], 4'b0000};

  always_comb begin
    loadData = dmem_rdata;
    case (funct3_q)
      3'b000:  loadData = {{24{byteLane[7]}}, byteLane[7:0]};
      3'b001:  loadData = {{16{halfLane[15]}}, halfLane[15:0]};
      3'b100:  loadData = {24'd0, byteLane[7:0]};
      3'b101:  loadData = {16'd0, halfLane[15:0]};
      default: loadData = dmem_rdata;
    endcase
  end

  // Next-state logic and the MEM/WB next values. While a bus access is being
  // accepted or is still waiting, MEM/WB takes a bubble. This keeps wb_stage
  // from seeing the previous instruction twice.
  always_comb begin
    state_d      = state_q;
    stallRaw     = 1'b0;
    dmem_req     = 1'b0;
    startAccess  = 1'b0;
    flushed_d    = flushed_q;
    wbValid_d    = 1'b0;
    wbRegWrite_d = 1'b0;
    wbMemToReg_d = mem_to_reg;
    wbJump_d     = jump;
    wbRd_d       = rd;
    wbPc_d       = pc;
    wbAlu_d      = alu_result;
    wbMem_d      = '0;
    misal_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && isMemOp && !flush && !misalignNew) begin
          stallRaw    = 1'b1;
          startAccess = 1'b1;
          flushed_d   = 1'b0;
          state_d     = ACCESS;
        end else begin
          wbValid_d    = in_valid & ~flush;
          wbRegWrite_d = in_valid & ~flush & reg_write & ~misalignNew;
          misal_d      = in_valid & ~flush & misalignNew;
        end
      end
      ACCESS: begin
        dmem_req     = 1'b1;
        stallRaw     = ~dmem_ready;
        wbMemToReg_d = memToReg_q;
        wbJump_d     = jump_q;
        wbRd_d       = rd_q;
        wbPc_d       = pc_q;
        wbAlu_d      = alu_q;
        if (flush) begin
          flushed_d = 1'b1;
        end
        if (dmem_ready) begin
          // The bus side effect has already happened. A flush seen at any
          // point in the access only turns the writeback into a bubble.
          wbValid_d    = ~(flushed_q | flush);
          wbRegWrite_d = ~(flushed_q | flush) & regWrite_q;
          wbMem_d      = load_q ? loadData : '0;
          flushed_d    = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // stall is forced low while reset is asserted, even if upstream still
  // presents a memory op.
  assign stall = stallRaw & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flushed_q <= flushed_d;
    end
  end

  // Request latch, loaded only when an access is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      load_q     <= 1'b0;
      funct3_q   <= '0;
      memToReg_q <= 1'b0;
      jump_q     <= 1'b0;
      regWrite_q <= 1'b0;
      rd_q       <= '0;
      pc_q       <= '0;
    end else if (startAccess) begin
      alu_q      <= alu_result;
      wdata_q    <= wdataNew;
      be_q       <= beNew;
      we_q       <= mem_write;
      load_q     <= mem_read & ~mem_write;
      funct3_q   <= funct3;
      memToReg_q <= mem_to_reg;
      jump_q     <= jump;
      regWrite_q <= reg_write;
      rd_q       <= rd;
      pc_q       <= pc;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbValid_q    <= 1'b0;
      wbMemToReg_q <= 1'b0;
      wbJump_q     <= 1'b0;
      wbRegWrite_q <= 1'b0;
      wbRd_q       <= '0;
      wbPc_q       <= '0;
      wbMem_q      <= '0;
      wbAlu_q      <= '0;
      misal_q      <= 1'b0;
    end else begin
      wbValid_q    <= wbValid_d;
      wbMemToReg_q <= wbMemToReg_d;
      wbJump_q     <= wbJump_d;
      wbRegWrite_q <= wbRegWrite_d;
      wbRd_q       <= wbRd_d;
      wbPc_q       <= wbPc_d;
      wbMem_q      <= wbMem_d;
      wbAlu_q      <= wbAlu_d;
      misal_q      <= misal_d;
    end
  end

  assign dmem_we        = we_q;
  assign dmem_addr      = {alu_q[WORD_SIZE-1:2], 2'b00};
  assign dmem_be        = be_q;
  assign dmem_wdata     = wdata_q;
  assign wb_valid       = wbValid_q;
  assign wb_mem_to_reg  = wbMemToReg_q;
  assign wb_jump        = wbJump_q;
  assign wb_reg_write   = wbRegWrite_q;
  assign wb_rd          = wbRd_q;
  assign wb_pc          = wbPc_q;
  assign wb_memory_data = wbMem_q;
  assign wb_alu_data    = wbAlu_q;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = misal_q;
`else
  logic unusedMisal;
  assign unusedMisal = misal_q;
`endif

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RV32I pipeline, between the execute stage and `wb_stage`. Takes the ALU result and store data from EX, runs byte/half/word loads and stores against a data memory with a ready handshake, and holds the MEM/WB pipeline register whose outputs feed `wb_stage` directly. Stalls upstream while a memory transaction is outstanding.

## Interface
- `WORD_SIZE`, 32, datapath width.
- `NUM_WORDS`, 1024, instruction memory depth; sets the PC width.
- `ADDR_SIZE`, $clog2(NUM_WORDS), PC width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: EX/MEM holds a real instruction.
- `flush` in 1: squash the instruction currently in MEM.
- `pc` in ADDR_SIZE: link value for jumps, passed through.
- `alu_result` in WORD_SIZE: effective address, or the result for non-memory ops.
- `rs2_data` in WORD_SIZE: store data.
- `mem_read`, `mem_write` in 1 each: load or store. Both high is illegal and treated as a store.
- `funct3` in 3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
- `mem_to_reg`, `jump`, `reg_write` in 1 each; `rd` in 5: writeback controls.
- `stall` out 1: upstream must hold its EX/MEM inputs stable.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out WORD_SIZE (word-aligned, [1:0]=0), `dmem_be` out 4, `dmem_wdata` out WORD_SIZE, `dmem_rdata` in WORD_SIZE, `dmem_ready` in 1: data memory port.
- `wb_valid`, `wb_mem_to_reg`, `wb_jump`, `wb_reg_write` out 1 each; `wb_rd` out 5; `wb_pc` out ADDR_SIZE; `wb_memory_data`, `wb_alu_data` out WORD_SIZE: MEM/WB register, feeding `wb_stage`.

## Operation
- FSM states:
  - IDLE (reset state).
  - ACCESS: request outstanding.
- IDLE, `in_valid` with no memory op, or `flush`: MEM/WB loads at the next edge. `stall`=0.
- IDLE, `in_valid` with a memory op and no `flush`:
  - `stall`=1.
  - Latch address, byte enables, aligned write data, `funct3`, and controls.
  - Go to ACCESS.
- ACCESS:
  - `dmem_req`=1, with `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata` held from the latch.
  - `stall`=!`dmem_ready`.
  - On `dmem_ready`: load MEM/WB from the latch plus the extracted load data, then return to IDLE.
- Store byte enables, using `a`=`alu_result[1:0]`:
  - SB: `4'b0001<<a`, data replicated ×4.
  - SH: `4'b0011<<{a[1],1'b0}`, data replicated ×2.
  - SW: `4'b1111`.
- Load extraction: select the byte or half from `dmem_rdata` by the latched `a`. Sign-extend for LB/LH, zero-extend for LBU/LHU. LW is taken as-is.
- For a non-load instruction, `wb_memory_data`=0.
- `wb_valid`=`in_valid`&!`flush` at load time.
- `wb_reg_write` is forced to 0 whenever `wb_valid`=0.
- `flush` in ACCESS:
  - The bus transaction still completes; side effects are never aborted.
  - The result is written to MEM/WB as a bubble (`wb_valid`=0, `wb_reg_write`=0).
  - The flush is remembered in a sticky bit until `dmem_ready`.
- Reset (any state, asynchronous):
  - FSM→IDLE, `dmem_req`=0, `stall`=0.
  - All `wb_*` outputs = 0.
  - A transaction in flight is dropped.

## Timing
- Non-memory instruction: 1 cycle, MEM/WB valid the cycle after it is presented.
- Memory op with `dmem_ready` in the first ACCESS cycle: 2 cycles, `stall` high for 1 cycle.
- Each extra wait cycle adds 1.
- `dmem_req` never drops before `dmem_ready`.
- Address, byte enables, and write data are stable for the whole request.
- `stall` is combinational from the state, `in_valid`, the op, and `dmem_ready`.
- Back-to-back loads: the second is accepted in the IDLE cycle right after the first completes. There are no idle bus cycles beyond that.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - An LH/LHU/SH with `a[0]`=1, or an LW/SW with `a`≠0, issues no bus request.
  - The stage completes in 1 cycle with `wb_reg_write`=0.
  - Adds an output `misaligned` (1 bit, registered alongside MEM/WB, reset 0), pulsed high for that instruction.
- Not defined:
  - There is no `misaligned` port.
  - Misaligned accesses use the aligned word, with lanes chosen by the rules above. Bits that spill past the word boundary are dropped.

## Test plan
- Reset mid-ACCESS with `dmem_ready` held at 0:
  - `rst_n` low → `dmem_req`=0, `stall`=0, all `wb_*`=0.
  - Post-reset, an ADD result 0x1234 passes through with `wb_alu_data`=0x1234 one cycle later.
- SB of 0xA5 at address 0x103:
  - `dmem_addr`=0x100, `dmem_be`=4'b1000, `dmem_wdata`=0xA5A5A5A5.
  - Completes in 2 cycles with `dmem_ready` immediate.
- LB and LBU at address 0x102 with `dmem_rdata`=0x00F70000:
  - LB → `wb_memory_data`=0xFFFFFFF7.
  - LBU → 0x000000F7.
  - `wb_mem_to_reg`=1.
- LH at 0x2 with 3 wait cycles, `dmem_rdata`=0x8001xxxx:
  - `stall` high for 4 cycles.
  - `wb_memory_data`=0xFFFF8001.
  - Request signals stable throughout.
- `flush` during ACCESS of an SW:
  - The store still completes on `dmem_ready`.
  - The MEM/WB result is `wb_valid`=0, `wb_reg_write`=0.
- With `MEM_MISALIGN_TRAP_EN`, LW at 0x101:
  - No `dmem_req`, `stall` stays 0.
  - Next cycle `misaligned`=1 and `wb_reg_write`=0.
